// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Instruction fetch front end. Owns the fetch PC, issues requests to
//           a one-cycle-latency instruction memory and buffers the returned
//           {pc, instruction} pairs in a small FIFO for the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [63:0] out_pc
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(DEPTH);
    localparam logic [31:0]        c_NOP     = 32'h0000_0013;

    logic [63:0]        r_fetch_pc;
    logic               r_inflight;
    logic [63:0]        r_inflight_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [63:0]        r_pc_mem  [DEPTH];
    logic [31:0]        r_ins_mem [DEPTH];

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W:0]   w_occupancy;

    // Slots already promised: buffered entries plus the response still due.
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue     = !reset && !redirect_valid && (w_occupancy < c_DEPTH);
    assign w_push      = !reset && !redirect_valid && r_inflight;
    assign w_pop       = !reset && !redirect_valid && out_valid && id_ready;

    assign imem_req        = w_issue;
    assign imem_addr       = r_fetch_pc;
    assign out_valid       = (r_count != '0);
    assign out_instruction = out_valid ? r_ins_mem[r_rd_ptr] : c_NOP;
    assign out_pc          = out_valid ? r_pc_mem[r_rd_ptr] : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 64'd0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 64'd4;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_inflight_pc;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
